// File: rtl/cyclic_prefix_stream.sv
// Streaming cyclic-prefix inserter: ping-pong symbol buffer on the write side,
// prefix-then-body replay on the read side, registered valid/ready output.
module cyclic_prefix_stream #(
    parameter int DATA_W = 16,
    parameter int N_FFT  = 64,
    parameter int CP_MAX = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(CP_MAX+1)-1:0]   cp_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_i,
    input  logic [DATA_W-1:0]             in_q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_i,
    output logic [DATA_W-1:0]             out_q,
    output logic                          out_sof,
    output logic                          out_eof,
    output logic                          out_is_cp,
    output logic [15:0]                   sym_cnt,
    output logic [1:0]                    o_dbg_state
);

    localparam int AW = $clog2(N_FFT);
    localparam int CW = $clog2(CP_MAX + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_FFT - 1);

    // Handshake rule for both ports: a sample moves on a rising edge where
    // valid and ready are both high; a valid sample holds until it moves.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREFIX = 2'd1,
        S_BODY   = 2'd2
    } state_t;

    logic [2*DATA_W-1:0] r_mem [2][N_FFT];
    logic [1:0]          r_full;
    logic [CW-1:0]       r_cp [2];
    logic                r_wr_bank;
    logic [AW-1:0]       r_wr_addr;
    logic                r_rd_bank;
    logic [AW-1:0]       r_rd_addr;
    state_t              r_state;

    logic                r_out_valid;
    logic                r_out_sof;
    logic                r_out_eof;
    logic                r_out_is_cp;
    logic [DATA_W-1:0]   r_out_i;
    logic [DATA_W-1:0]   r_out_q;
    logic [15:0]         r_sym_cnt;

    logic                w_wr_fire;
    logic [AW-1:0]       w_wr_addr;
    logic                w_wr_last;
    logic [CW-1:0]       w_cp_clamp;

    logic                w_load;
    logic [CW-1:0]       w_cp_rd;
    logic [AW-1:0]       w_cp_start;
    state_t              w_state_nxt;
    logic [AW-1:0]       w_rd_addr_nxt;
    logic [AW-1:0]       w_raddr;
    logic                w_emit;
    logic                w_sof;
    logic                w_eof;
    logic                w_is_cp;
    logic                w_rd_done;
    logic [1:0]          w_full_nxt;

    // ---------------- write side ----------------
    assign in_ready   = !r_full[r_wr_bank];
    assign w_wr_fire  = in_valid && in_ready;
    // An in_sof arriving mid-symbol restarts framing at address 0.
    assign w_wr_addr  = in_sof ? '0 : r_wr_addr;
    assign w_wr_last  = (w_wr_addr == LAST_ADDR);
    assign w_cp_clamp = (cp_len > CW'(CP_MAX)) ? CW'(CP_MAX) : cp_len;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][w_wr_addr] <= {in_i, in_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_cp[0]   <= '0;
            r_cp[1]   <= '0;
        end else if (w_wr_fire) begin
            if (w_wr_addr == '0) begin
                r_cp[r_wr_bank] <= w_cp_clamp;
            end
            if (w_wr_last) begin
                r_wr_bank <= !r_wr_bank;
                r_wr_addr <= '0;
            end else begin
                r_wr_addr <= w_wr_addr + AW'(1);
            end
        end
    end

    // Writer only touches a non-full bank and the reader only frees a full
    // one, so a set and a clear in the same cycle always hit different bits.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // ---------------- read side ----------------
    assign w_load     = !r_out_valid || out_ready;
    assign w_cp_rd    = r_cp[r_rd_bank];
    assign w_cp_start = AW'(N_FFT - int'(w_cp_rd));

    // IDLE launches the first sample of a full bank itself, so returning to
    // IDLE after a body costs no cycle when the other bank is already waiting.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_addr_nxt = r_rd_addr;
        w_raddr       = r_rd_addr;
        w_emit        = 1'b0;
        w_sof         = 1'b0;
        w_eof         = 1'b0;
        w_is_cp       = 1'b0;
        w_rd_done     = 1'b0;
        if (w_load) begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        w_emit = 1'b1;
                        w_sof  = 1'b1;
                        if (w_cp_rd != '0) begin
                            w_raddr = w_cp_start;
                            w_is_cp = 1'b1;
                            if (w_cp_start == LAST_ADDR) begin
                                w_state_nxt   = S_BODY;
                                w_rd_addr_nxt = '0;
                            end else begin
                                w_state_nxt   = S_PREFIX;
                                w_rd_addr_nxt = w_cp_start + AW'(1);
                            end
                        end else begin
                            w_raddr       = '0;
                            w_state_nxt   = S_BODY;
                            w_rd_addr_nxt = AW'(1);
                        end
                    end
                end
                S_PREFIX: begin
                    w_emit  = 1'b1;
                    w_is_cp = 1'b1;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_state_nxt   = S_BODY;
                        w_rd_addr_nxt = '0;
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + AW'(1);
                    end
                end
                S_BODY: begin
                    w_emit = 1'b1;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_eof         = 1'b1;
                        w_rd_done     = 1'b1;
                        w_state_nxt   = S_IDLE;
                        w_rd_addr_nxt = '0;
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + AW'(1);
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_rd_addr_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_rd_bank <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            if (w_rd_done) begin
                r_rd_bank <= !r_rd_bank;
                r_sym_cnt <= r_sym_cnt + 16'd1;
            end
        end
    end

    // Output register: refills whenever empty or being drained, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_is_cp <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
        end else if (w_load) begin
            r_out_valid <= w_emit;
            r_out_sof   <= w_sof;
            r_out_eof   <= w_eof;
            r_out_is_cp <= w_is_cp;
            if (w_emit) begin
                {r_out_i, r_out_q} <= r_mem[r_rd_bank][w_raddr];
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_sof     = r_out_sof;
    assign out_eof     = r_out_eof;
    assign out_is_cp   = r_out_is_cp;
    assign out_i       = r_out_i;
    assign out_q       = r_out_q;
    assign sym_cnt     = r_sym_cnt;
    assign o_dbg_state = r_state;

endmodule
